// File: rtl/vc_fifo.sv
// Purpose : NUM_CHANNELS independent circular FIFOs sharing one storage array ({channel, pointer}).
// Latency : 1 cycle from accepted read request to o_read_packet/o_read_valid; writes visible next cycle.
// Backpres: none on the ports; writes to a full channel and reads from an empty channel are dropped.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   i_write_packet_en/_channel/_packet   write request, target channel, data
//   i_read_packet_en/_channel            read request, source channel
//   o_read_packet, o_read_valid          registered read data, one-cycle valid pulse
//   o_empty_flags/o_full_flags/o_almost_full_flags   per-channel status, bit n = channel n
//   o_count                              per-channel occupancy, channel n at [n*C +: C]
// Optional (define VC_FIFO_ERR_FLAGS_EN):
//   i_err_clear, o_overflow_flags, o_underflow_flags  sticky per-channel error bits
module vc_fifo #(
  parameter int NUM_CHANNELS       = 4,
  parameter int LOG2_NUM_CHANNELS  = 2,
  parameter int FIFO_DEPTH         = 8,
  parameter int LOG2_FIFO_DEPTH    = 3,
  parameter int DATA_LINE_WIDTH    = 64,
  parameter int CONTROL_LINE_WIDTH = 6,
  parameter int ALMOST_FULL_THRESH = 6
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             i_write_packet_en,
  input  logic [LOG2_NUM_CHANNELS-1:0]                     i_write_channel,
  input  logic [DATA_LINE_WIDTH+CONTROL_LINE_WIDTH-1:0]    i_write_packet,
  input  logic                                             i_read_packet_en,
  input  logic [LOG2_NUM_CHANNELS-1:0]                     i_read_channel,
  output logic [DATA_LINE_WIDTH+CONTROL_LINE_WIDTH-1:0]    o_read_packet,
  output logic                                             o_read_valid,
  output logic [NUM_CHANNELS-1:0]                          o_empty_flags,
  output logic [NUM_CHANNELS-1:0]                          o_full_flags,
  output logic [NUM_CHANNELS-1:0]                          o_almost_full_flags,
`ifdef VC_FIFO_ERR_FLAGS_EN
  input  logic                                             i_err_clear,
  output logic [NUM_CHANNELS-1:0]                          o_overflow_flags,
  output logic [NUM_CHANNELS-1:0]                          o_underflow_flags,
`endif
  output logic [NUM_CHANNELS*(LOG2_FIFO_DEPTH+1)-1:0]      o_count
);

  localparam int W      = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;
  localparam int C      = LOG2_FIFO_DEPTH + 1;
  localparam int MEM_AW = LOG2_NUM_CHANNELS + LOG2_FIFO_DEPTH;

  // Shared storage; never reset, contents are only meaningful between head and tail.
  logic [W-1:0]                 mem [2**MEM_AW];

  logic [LOG2_FIFO_DEPTH-1:0]   head      [NUM_CHANNELS];
  logic [LOG2_FIFO_DEPTH-1:0]   tail      [NUM_CHANNELS];
  logic [C-1:0]                 count     [NUM_CHANNELS];
  logic [C-1:0]                 count_nxt [NUM_CHANNELS];

  logic wr_ch_ok;
  logic rd_ch_ok;
  logic wr_acc;
  logic rd_acc;

  // Channel range check only matters when the index field can encode more
  // channels than exist; otherwise every encoding is a real channel.
  generate
    if (NUM_CHANNELS < (1 << LOG2_NUM_CHANNELS)) begin : g_ch_chk
      assign wr_ch_ok = (int'(i_write_channel) < NUM_CHANNELS);
      assign rd_ch_ok = (int'(i_read_channel) < NUM_CHANNELS);
    end else begin : g_ch_all
      assign wr_ch_ok = 1'b1;
      assign rd_ch_ok = 1'b1;
    end
  endgenerate

  // Acceptance uses start-of-cycle counts: a full channel cannot reuse the
  // slot freed by a same-cycle read, and an empty channel cannot forward a
  // same-cycle write to the read port.
  assign wr_acc = i_write_packet_en && wr_ch_ok &&
                  (count[i_write_channel] < C'(FIFO_DEPTH));
  assign rd_acc = i_read_packet_en && rd_ch_ok &&
                  (count[i_read_channel] != '0);

  // Occupancy update: +1 write only, -1 read only, unchanged for both/neither.
  always_comb begin
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      count_nxt[n] = count[n];
      if (wr_acc && (i_write_channel == LOG2_NUM_CHANNELS'(n)))
        count_nxt[n] = count_nxt[n] + C'(1);
      if (rd_acc && (i_read_channel == LOG2_NUM_CHANNELS'(n)))
        count_nxt[n] = count_nxt[n] - C'(1);
    end
  end

  // Pointers, counts and the registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NUM_CHANNELS; n++) begin
        head[n]  <= '0;
        tail[n]  <= '0;
        count[n] <= '0;
      end
      o_read_packet <= '0;
      o_read_valid  <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_CHANNELS; n++) begin
        count[n] <= count_nxt[n];
      end
      o_read_valid <= rd_acc;
      if (rd_acc) begin
        o_read_packet          <= mem[{i_read_channel, head[i_read_channel]}];
        // Depth is a power of two, so the pointer wraps naturally.
        head[i_read_channel]   <= head[i_read_channel] + LOG2_FIFO_DEPTH'(1);
      end
      if (wr_acc) begin
        tail[i_write_channel]  <= tail[i_write_channel] + LOG2_FIFO_DEPTH'(1);
      end
    end
  end

  // Storage write; gated by rst so a write pending during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[{i_write_channel, tail[i_write_channel]}] <= i_write_packet;
    end
  end

  // Status flags are pure functions of the registered counts.
  always_comb begin
    o_empty_flags       = '0;
    o_full_flags        = '0;
    o_almost_full_flags = '0;
    o_count             = '0;
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      o_empty_flags[n]       = (count[n] == '0);
      o_full_flags[n]        = (count[n] == C'(FIFO_DEPTH));
      o_almost_full_flags[n] = (count[n] >= C'(ALMOST_FULL_THRESH));
      o_count[n*C +: C]      = count[n];
    end
  end

`ifdef VC_FIFO_ERR_FLAGS_EN
  logic [NUM_CHANNELS-1:0] ovf_set;
  logic [NUM_CHANNELS-1:0] unf_set;

  // Error events are judged on the raw request, before acceptance gating.
  always_comb begin
    ovf_set = '0;
    unf_set = '0;
    if (i_write_packet_en && wr_ch_ok && (count[i_write_channel] == C'(FIFO_DEPTH)))
      ovf_set = NUM_CHANNELS'(1) << i_write_channel;
    if (i_read_packet_en && rd_ch_ok && (count[i_read_channel] == '0))
      unf_set = NUM_CHANNELS'(1) << i_read_channel;
  end

  // Sticky bits; a same-cycle set overrides the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_overflow_flags  <= '0;
      o_underflow_flags <= '0;
    end else begin
      o_overflow_flags  <= ovf_set | (i_err_clear ? '0 : o_overflow_flags);
      o_underflow_flags <= unf_set | (i_err_clear ? '0 : o_underflow_flags);
    end
  end
`endif

endmodule

// File: doc/vc_fifo.md
VC_FIFO -- requirements
Module: vc_fifo

Interface
REQ-001 Parameters SHALL be: NUM_CHANNELS 4, number of independent channel queues; LOG2_NUM_CHANNELS 2, channel index width; FIFO_DEPTH 8, entries per channel (power of two); LOG2_FIFO_DEPTH 3, pointer width; DATA_LINE_WIDTH 64, data bits; CONTROL_LINE_WIDTH 6, control bits; ALMOST_FULL_THRESH 6, almost-full level.
REQ-002 Packet width W SHALL be DATA_LINE_WIDTH+CONTROL_LINE_WIDTH; count width C SHALL be LOG2_FIFO_DEPTH+1.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 i_write_packet_en  input  1  write request.
REQ-007 i_write_channel  input  LOG2_NUM_CHANNELS  target channel of write.
REQ-008 i_write_packet  input  W  write data.
REQ-009 i_read_packet_en  input  1  read request.
REQ-010 i_read_channel  input  LOG2_NUM_CHANNELS  source channel of read.
REQ-011 o_read_packet  output  W  registered read data.
REQ-012 o_read_valid  output  1  o_read_packet updated this cycle.
REQ-013 o_empty_flags / o_full_flags / o_almost_full_flags  output  NUM_CHANNELS each  per-channel status, bit n = channel n.
REQ-014 o_count  output  NUM_CHANNELS*C  per-channel occupancy, channel n at bits [n*C +: C].

Function
REQ-015 Each channel SHALL be an independent circular buffer with its own head pointer, tail pointer and count; storage MAY be one shared array indexed {channel, pointer}.
REQ-016 A write SHALL be accepted iff i_write_packet_en=1, i_write_channel<NUM_CHANNELS and that channel's count (start of cycle) < FIFO_DEPTH.
REQ-017 A read SHALL be accepted iff i_read_packet_en=1, i_read_channel<NUM_CHANNELS and that channel's count (start of cycle) > 0.
REQ-018 Accepted write: packet stored at tail, tail increments modulo FIFO_DEPTH (natural wrap DEPTH-1 -> 0).
REQ-019 Accepted read: o_read_packet <= entry at head on the next edge, o_read_valid=1 for exactly that one cycle, head increments modulo FIFO_DEPTH.
REQ-020 Read latency SHALL be 1 cycle; with no accepted read o_read_valid=0 and o_read_packet holds its last value.
REQ-021 Count per channel SHALL change +1 (write only), -1 (read only), 0 (both or neither).
REQ-022 Simultaneous write and read on different channels SHALL both proceed independently in one cycle.
REQ-023 Same channel, full: read accepted, write rejected (no same-cycle slot reuse).
REQ-024 Same channel, empty: write accepted, read rejected (no write-to-read bypass).
REQ-025 Same channel, partially filled: both accepted, count unchanged, order preserved.
REQ-026 Flags SHALL be combinational from counts: empty = (count==0), full = (count==FIFO_DEPTH), almost_full = (count>=ALMOST_FULL_THRESH).
REQ-027 Rejected requests SHALL leave all state unchanged and SHALL NOT corrupt stored data.
REQ-028 Channel indices >= NUM_CHANNELS SHALL be ignored.

Reset
REQ-029 With rst=1 at an edge: all pointers and counts 0, o_read_packet 0, o_read_valid 0, error flags 0; storage array not reset.
REQ-030 rst SHALL take priority over any same-cycle read or write; pending entries are discarded (reset mid-operation empties all channels).

Configuration
REQ-031 Macro VC_FIFO_ERR_FLAGS_EN, when defined, SHALL add ports i_err_clear (input 1), o_overflow_flags (output NUM_CHANNELS), o_underflow_flags (output NUM_CHANNELS).
REQ-032 With macro: write request to a full channel sets o_overflow_flags[ch]; read request to an empty channel sets o_underflow_flags[ch]; bits are sticky until i_err_clear=1; set wins over clear in the same cycle.
REQ-033 Without macro: those ports and registers SHALL not exist; rejected requests are silently dropped; all other behaviour identical.

Verification
REQ-034 Reset, then write 0x11,0x22,0x33 to ch0 and read ch0 x3 -> o_read_valid pulses, data 0x11,0x22,0x33 one cycle after each read; count ch0 3 -> 0.
REQ-035 Fill ch2 with 8 writes -> almost_full[2] at count 6, full[2] at 8; 9th write rejected; 8 reads return data in order with pointer wrap.
REQ-036 ch1 full, same-cycle write+read on ch1 -> read accepted, write rejected, count 7; ch3 empty, write+read -> count 1, o_read_valid 0.
REQ-037 Interleave writes to ch0 and reads from ch3 every cycle for 20 cycles -> no cross-channel data, counts match model.
REQ-038 Load ch0 with 5 entries, assert rst for one cycle with write pending -> all counts 0, all empty flags 1, o_read_valid 0, pending write dropped.
REQ-039 With VC_FIFO_ERR_FLAGS_EN: read empty ch2 -> o_underflow_flags=4'b0100; write full ch1 -> o_overflow_flags=4'b0010; i_err_clear -> both 0.
